lsu_bus_master: RTL and testbench

//  Load/store initiator for the RV32I EX->MEM boundary. Turns EX-stage memread/memwrite

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_bus_master_align.sv | 55 +++++
 rtl/lsu_bus_master.sv | 141 ++++++++++++++
 tb/tb_lsu_bus_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: FSM states, funct3 codes,
// byte-strobe masks and the access-legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Halves need addr[0]==0, words need addr[1:0]==0; unknown encodings are illegal.
  function automatic logic lsu_legal(input logic [2:0] f3, input logic is_store,
                                     input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~a[0];
        F3_SW:   ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~a[0];
        F3_LW:         ok = (a == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_bus_master_align.sv
// Combinational data path: store strobe/lane replication and load lane
// extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = '0;
    wdata = '0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          wstrb = STRB_B << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          wstrb = STRB_H << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
        F3_SW: begin
          wstrb = STRB_W;
          wdata = store_data;
        end
        default: begin
          wstrb = '0;
          wdata = '0;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = load_word >> {addr_lo, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// RV32I load/store initiator on a valid/ready data-memory bus; stalls the pipeline
// until the response returns. Optional WAIT timeout under `LSU_TIMEOUT_EN.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              memread_ex,
  input  logic              memwrite_ex,
  input  logic [2:0]        funct3_ex,
  input  logic              exmem_flush,
  input  logic [31:0]       aluresult_ex,
  input  logic [31:0]       forwardBout_ex,
  output logic              lsu_stall,
  output logic [31:0]       dmemrd_mem,
  output logic              mem_access_fault,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata,
  input  logic              rsp_err
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, data_q, dmemrd_q, load_data;
  logic [2:0]  f3_q;
  logic        we_q, fault_q, fault_d;
  logic        access, legal, capture, rsp_take, tmo_hit;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]  tmo_q;
  logic        unused_cfg;
  assign unused_cfg = |DATA_W;
`else
  logic        unused_cfg;
  assign unused_cfg = |{DATA_W, TIMEOUT};
`endif

  always_comb begin
    access    = (memread_ex | memwrite_ex) & ~exmem_flush;
    legal     = lsu_legal(funct3_ex, memwrite_ex, aluresult_ex[1:0]);
    state_d   = state_q;
    capture   = 1'b0;
    rsp_take  = 1'b0;
    tmo_hit   = 1'b0;
    fault_d   = 1'b0;
    lsu_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (legal) begin
            capture   = 1'b1;
            lsu_stall = 1'b1;
            state_d   = S_REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        if (rsp_valid) begin
          rsp_take = 1'b1;
          fault_d  = rsp_err;
          state_d  = S_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          fault_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      dmemrd_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (capture) begin
        addr_q <= aluresult_ex;
        data_q <= forwardBout_ex;
        f3_q   <= funct3_ex;
        we_q   <= memwrite_ex;
      end
      // An errored or timed-out access leaves zero, even for stores.
      if (tmo_hit || (rsp_take && rsp_err)) dmemrd_q <= '0;
      else if (rsp_take && !we_q)           dmemrd_q <= load_data;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 tmo_q <= '0;
    else if (state_q == S_WAIT) tmo_q <= tmo_q + 8'd1;
    else                       tmo_q <= '0;
  end
`endif

  lsu_align u_align (
    .funct3     (f3_q),
    .we         (we_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (data_q),
    .load_word  (rsp_rdata),
    .wstrb      (req_wstrb),
    .wdata      (req_wdata),
    .load_data  (load_data)
  );

  assign req_valid        = (state_q == S_REQ);
  assign req_we           = we_q;
  assign req_addr         = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmemrd_mem       = dmemrd_q;
  assign mem_access_fault = fault_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: vector table of single accesses plus
// hand-written multi-cycle sequences (backpressure, faults, flush, reset).
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        memread_ex, memwrite_ex, exmem_flush;
  logic [2:0]  funct3_ex;
  logic [31:0] aluresult_ex, forwardBout_ex;
  logic        lsu_stall, mem_access_fault;
  logic [31:0] dmemrd_mem;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rstn(rstn),
    .memread_ex(memread_ex), .memwrite_ex(memwrite_ex), .funct3_ex(funct3_ex),
    .exmem_flush(exmem_flush), .aluresult_ex(aluresult_ex), .forwardBout_ex(forwardBout_ex),
    .lsu_stall(lsu_stall), .dmemrd_mem(dmemrd_mem), .mem_access_fault(mem_access_fault),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
  } bad_t;

  vec_t vecs[11];
  bad_t bads[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ex_idle();
    memread_ex = 1'b0; memwrite_ex = 1'b0; exmem_flush = 1'b0;
  endtask

  task automatic ex_drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
    memwrite_ex = we; memread_ex = ~we; funct3_ex = f3;
    aluresult_ex = a; forwardBout_ex = d;
  endtask

  // Immediate ready/response; rsp_valid is held high throughout since it is
  // ignored outside WAIT.
  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    bit done;
    stalls = 0;
    done = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d fault_clear", idx), {31'b0, mem_access_fault}, 32'd0);
    rsp_rdata = v.rdata; rsp_err = v.err; req_ready = 1'b1; rsp_valid = 1'b1;
    ex_drive(v.we, v.f3, v.addr, v.sdata);
    #1;
    if (lsu_stall) stalls++;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (req_valid) begin
        chk($sformatf("v%0d req_addr", idx), req_addr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d req_we", idx), {31'b0, req_we}, {31'b0, v.we});
        chk($sformatf("v%0d req_wstrb", idx), {28'b0, req_wstrb}, {28'b0, v.exp_strb});
        chk($sformatf("v%0d req_wdata", idx), req_wdata, v.exp_wdata);
      end
      if (lsu_stall) stalls++;
      else done = 1'b1;
    end
    ex_idle();
    rsp_valid = 1'b0; rsp_err = 1'b0;
    chk($sformatf("v%0d stall_cycles", idx), stalls, 3);
    chk($sformatf("v%0d dmemrd", idx), dmemrd_mem, v.exp_rd);
    chk($sformatf("v%0d fault", idx), {31'b0, mem_access_fault}, {31'b0, v.exp_fault});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //            we  f3      addr          sdata         rdata         err  exp_rd        strb     wdata         fault
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_5511, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80AA_5511, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80AA_5511, 1'b0, 32'hFFFF_80AA, 4'b0000, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h80AA_5511, 1'b0, 32'h0000_5511, 4'b0000, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h80AA_5511, 1'b0, 32'h0000_0055, 4'b0000, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_00C3, 32'hFFFF_FFFF, 1'b0, 32'h0000_0055, 4'b0010, 32'hC3C3_C3C3, 1'b0};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 32'h0000_0055, 4'b1100, 32'hABCD_ABCD, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 32'h0000_0055, 4'b1111, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0208, 32'h0,        32'h7F00_FF01, 1'b0, 32'h7F00_FF01, 4'b0000, 32'h0,        1'b0};

    bads[0] = '{1'b0, 3'b010, 32'h0000_0102};
    bads[1] = '{1'b0, 3'b001, 32'h0000_0101};
    bads[2] = '{1'b0, 3'b101, 32'h0000_0103};
    bads[3] = '{1'b0, 3'b011, 32'h0000_0100};
    bads[4] = '{1'b0, 3'b110, 32'h0000_0100};
    bads[5] = '{1'b1, 3'b001, 32'h0000_0103};
    bads[6] = '{1'b1, 3'b010, 32'h0000_0101};
    bads[7] = '{1'b1, 3'b011, 32'h0000_0100};
    bads[8] = '{1'b1, 3'b100, 32'h0000_0100};

    rstn = 1'b0;
    ex_idle();
    funct3_ex = '0; aluresult_ex = '0; forwardBout_ex = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    #12;
    chk("rst req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst dmemrd", dmemrd_mem, 32'd0);
    chk("rst fault", {31'b0, mem_access_fault}, 32'd0);
    chk("rst req_addr", req_addr, 32'd0);
    chk("rst req_wstrb", {28'b0, req_wstrb}, 32'd0);
    chk("rst req_we", {31'b0, req_we}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Backpressure: SB held in REQ for 4 cycles; EX operands change underneath.
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
    ex_drive(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00C3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      aluresult_ex = 32'h0000_0F0E; forwardBout_ex = 32'h5555_5555;
      chk($sformatf("bp%0d req_valid", c), {31'b0, req_valid}, 32'd1);
      chk($sformatf("bp%0d req_addr", c), req_addr, 32'h0000_0100);
      chk($sformatf("bp%0d req_wstrb", c), {28'b0, req_wstrb}, 32'h2);
      chk($sformatf("bp%0d req_wdata", c), req_wdata, 32'hC3C3_C3C3);
      chk($sformatf("bp%0d req_we", c), {31'b0, req_we}, 32'd1);
      chk($sformatf("bp%0d stall", c), {31'b0, lsu_stall}, 32'd1);
    end
    req_ready = 1'b1;
    @(negedge clk);
    chk("bp wait req_valid", {31'b0, req_valid}, 32'd0);
    chk("bp wait stall", {31'b0, lsu_stall}, 32'd1);
    rsp_valid = 1'b1;
    @(negedge clk);
    chk("bp done stall", {31'b0, lsu_stall}, 32'd0);
    ex_idle();
    rsp_valid = 1'b0;

    // Illegal accesses: no request, no stall, single-cycle fault pulse.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ex_drive(bads[i].we, bads[i].f3, bads[i].addr, 32'h1111_2222);
      #1;
      chk($sformatf("bad%0d stall", i), {31'b0, lsu_stall}, 32'd0);
      @(negedge clk);
      ex_idle();
      chk($sformatf("bad%0d fault", i), {31'b0, mem_access_fault}, 32'd1);
      chk($sformatf("bad%0d req_valid", i), {31'b0, req_valid}, 32'd0);
      @(negedge clk);
      chk($sformatf("bad%0d fault_end", i), {31'b0, mem_access_fault}, 32'd0);
      chk($sformatf("bad%0d req_valid2", i), {31'b0, req_valid}, 32'd0);
    end

    // Flushed legal load: nothing happens.
    @(negedge clk);
    ex_drive(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    exmem_flush = 1'b1;
    #1;
    chk("flush stall", {31'b0, lsu_stall}, 32'd0);
    @(negedge clk);
    chk("flush req_valid", {31'b0, req_valid}, 32'd0);
    chk("flush fault", {31'b0, mem_access_fault}, 32'd0);
    ex_idle();

    // Reset while REQ is pending.
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b0;
    ex_drive(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    @(negedge clk);
    chk("rreq req_valid", {31'b0, req_valid}, 32'd1);
    #2 rstn = 1'b0;
    ex_idle();
    #1;
    chk("rreq req_valid_rst", {31'b0, req_valid}, 32'd0);
    chk("rreq stall_rst", {31'b0, lsu_stall}, 32'd0);
    chk("rreq dmemrd_rst", dmemrd_mem, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset while waiting for the response.
    @(negedge clk);
    req_ready = 1'b1; rsp_valid = 1'b0;
    ex_drive(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rwait stall", {31'b0, lsu_stall}, 32'd1);
    chk("rwait req_valid", {31'b0, req_valid}, 32'd0);
    #2 rstn = 1'b0;
    ex_idle();
    #1;
    chk("rwait stall_rst", {31'b0, lsu_stall}, 32'd0);
    chk("rwait req_valid_rst", {31'b0, req_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_vec(vecs[0], 100);

`ifdef LSU_TIMEOUT_EN
    begin
      int stalls;
      bit done;
      stalls = 0;
      done = 1'b0;
      @(negedge clk);
      req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = 32'h1357_9BDF;
      ex_drive(1'b0, 3'b010, 32'h0000_0400, 32'h0);
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        if (lsu_stall) stalls++;
        else done = 1'b1;
      end
      ex_idle();
      chk("tmo stall_cycles", stalls, 256);
      chk("tmo fault", {31'b0, mem_access_fault}, 32'd1);
      chk("tmo dmemrd", dmemrd_mem, 32'd0);
      rsp_valid = 1'b1;
      @(negedge clk);
      chk("tmo late fault", {31'b0, mem_access_fault}, 32'd0);
      chk("tmo late dmemrd", dmemrd_mem, 32'd0);
      chk("tmo late stall", {31'b0, lsu_stall}, 32'd0);
      rsp_valid = 1'b0;
    end
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
